ftq: RTL and testbench
======================

Name: ftq

Overview:
Fetch target queue that consumes the predictor's pcg_bundle_t stream. It buffers each prediction bundle, keyed by its FTQ id, and serves fetch blocks in order to the fetch unit. It accepts branch resolutions from the backend and drives the predictor update interface (redir/reinf and the associated fields). It is the receiving end of the predictor's output bundle and the sending end of its update port.

Parameters:
DEPTH, 32, number of entries; power of 2, at most 128; entry index = id[$clog2(DEPTH)-1:0]
FNUM, 4, slots per bundle; must equal the predictor's fnum
CNT, 2, counter width; must equal the predictor's cnt

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pg_in  in  pcg_bundle_t  prediction bundle; valid when pg_in.id[7]
pg_ready  out  1  ready to the predictor; = ~full & ~redir
f_valid  out  1  fetch block available
f_ready  in  1  fetch unit accepts the block
f_pc  out  64  block start PC
f_num  out  8  halfword slots in the block
f_id  out  7  FTQ id of the block
res_valid  in  1  branch resolution
res_id  in  7  FTQ id of the resolved branch
res_slot  in  8  slot within the bundle; must be < FNUM
res_mispred  in  1  prediction wrong
res_target  in  64  actual next PC
cm_valid  in  1  commit: frees the head entry
redir  out  1  update: mispredict
reinf  out  1  update: correct prediction
upc  out  64  updating PC
unpc  out  64  updating next PC
ubk  out  5  bank vector of the slot
upat  out  8  pattern of the slot
upatb  out  8  bimodal pattern of the slot
ugh  out  16  global-history position of the slot
ughi  out  4x16  folded index history of the slot
ught  out  4x16  folded tag history of the slot

Behaviour:
- Reset (async): head, fetch and tail pointers = 0, all valid bits = 0, redir = reinf = 0, f_valid = 0. All other update outputs are 0.
- Pointers are ($clog2(DEPTH)+1) bits wide, including a wrap bit. full = tail vs head differ only in the wrap bit. empty = tail == head.
- Enqueue: when pg_in.id[7] & pg_ready, store pc, num, and per-slot bank, pat, patb, gh, ghi, ght at tail[idx]. Then tail++.
- pg_in.id[6:0] must equal tail[6:0] at enqueue; a mismatch fires an assertion.
- Fetch: f_valid = fetch != tail. Outputs are read combinationally from entry[fetch]. fetch++ on f_valid & f_ready.
- Commit: cm_valid with head != fetch frees entry[head] and increments head. cm_valid in any other case is ignored and fires an assertion.
- Resolution latency is 1 cycle. res_valid at cycle t with a valid entry registers these outputs at t+1, pulsed for exactly one cycle:
  - redir = res_mispred, reinf = ~res_mispred
  - upc = entry.pc + {res_slot, 1'b0}
  - unpc = res_target
  - ubk/upat/upatb/ugh/ughi/ught = the entry's fields for res_slot
- Resolution to an invalid entry, or res_slot >= FNUM: no update, and an assertion fires.
- Redirect flush: on the edge that sets redir = 1, clear all valid bits and set head = fetch = tail = 0. This matches the predictor restarting its id at 0.
- During the redir cycle pg_ready = 0, and any pg_in is dropped. Enqueue resumes the next cycle with id 0.
- Simultaneous events:
  - res_valid with mispredict plus enqueue, fetch or commit in the same cycle: those actions take effect normally at t+1, then the flush overrides the pointers.
  - A second res_valid arriving while redir is high is ignored.
- Enqueue and commit in the same cycle while full: commit frees a slot only the next cycle. pg_ready stays 0 that cycle.
- Pointer arithmetic wraps modulo 2*DEPTH.

Decomposition:
- Shared types package: pcg_bundle_t (existing), plus new ftq_entry_t {pc, num, bank/pat/patb/gh/ghi/ght [FNUM]} and ftq_upd_t (the update bundle).
- One sub-module, ftq_ram: DEPTH x ftq_entry_t storage with one write port and two async read ports (fetch, resolve).

Test Plan:
- Reset, then 3 bundles with pc = 0x8000_0000/0x8000_0008/0x8000_0010, num = 4, ids 0..2, f_ready = 1 -> f_pc follows the same order, f_id = 0,1,2, f_valid low after the third.
- Fill 32 bundles with no commit -> pg_ready = 0 once 32 entries are held. One cm_valid -> pg_ready = 1 the cycle after.
- Enqueue id 5 with bank[2] = 5'b00110, pat[2] = 8'h2, pc = 0x1000. Then res_valid, id 5, slot 2, mispred = 0, target = 0x2000 -> next cycle reinf = 1, redir = 0, upc = 0x1004, unpc = 0x2000, ubk = 5'b00110, upat = 8'h2.
- Same setup with mispred = 1 -> redir = 1 for one cycle, pg_ready = 0 that cycle, f_valid = 0 after. The next enqueue is accepted with id 0.
- Mispredict resolution in the same cycle as enqueue and f_ready -> queue empty after the flush, redir = 1 once, the concurrent enqueue has no effect.
- Assert rst asynchronously mid-stream between clock edges -> redir = reinf = f_valid = 0 immediately; tail = 0 on the next enqueue.

Source files
------------

// File: rtl/ftq_pkg.sv
// Shared types for the fetch target queue.
//   pcg_bundle_t : prediction bundle produced by the predictor (id[7] = valid)
//   ftq_entry_t  : one stored fetch block (bundle without its id)
//   ftq_upd_t    : registered predictor update bundle driven by the FTQ
package ftq_pkg;

    localparam int unsigned FTQ_FNUM = 4;   // slots per bundle
    localparam int unsigned FTQ_CNT  = 2;   // predictor counter width
    localparam int unsigned FTQ_NH   = 4;   // folded history tables per slot

    typedef struct packed {
        logic [7:0]                                id;
        logic [63:0]                               pc;
        logic [7:0]                                num;
        logic [FTQ_FNUM-1:0][4:0]                  bank;
        logic [FTQ_FNUM-1:0][7:0]                  pat;
        logic [FTQ_FNUM-1:0][7:0]                  patb;
        logic [FTQ_FNUM-1:0][15:0]                 gh;
        logic [FTQ_FNUM-1:0][FTQ_NH-1:0][15:0]     ghi;
        logic [FTQ_FNUM-1:0][FTQ_NH-1:0][15:0]     ght;
    } pcg_bundle_t;

    typedef struct packed {
        logic [63:0]                               pc;
        logic [7:0]                                num;
        logic [FTQ_FNUM-1:0][4:0]                  bank;
        logic [FTQ_FNUM-1:0][7:0]                  pat;
        logic [FTQ_FNUM-1:0][7:0]                  patb;
        logic [FTQ_FNUM-1:0][15:0]                 gh;
        logic [FTQ_FNUM-1:0][FTQ_NH-1:0][15:0]     ghi;
        logic [FTQ_FNUM-1:0][FTQ_NH-1:0][15:0]     ght;
    } ftq_entry_t;

    typedef struct packed {
        logic                        redir;
        logic                        reinf;
        logic [63:0]                 pc;
        logic [63:0]                 npc;
        logic [4:0]                  bk;
        logic [7:0]                  pat;
        logic [7:0]                  patb;
        logic [15:0]                 gh;
        logic [FTQ_NH-1:0][15:0]     ghi;
        logic [FTQ_NH-1:0][15:0]     ght;
    } ftq_upd_t;

endpackage

// File: rtl/ftq_ram.sv
// FTQ entry storage: DEPTH x ftq_entry_t, one synchronous write port and
// two asynchronous read ports (fetch side and resolve side).
//   clk_i                : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_f_i/rdata_f_o  : fetch read port
//   raddr_r_i/rdata_r_o  : resolve read port
module ftq_ram
    import ftq_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  ftq_entry_t                 wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_f_i,
    output ftq_entry_t                 rdata_f_o,
    input  logic [$clog2(DEPTH)-1:0]   raddr_r_i,
    output ftq_entry_t                 rdata_r_o
);

    ftq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_f_o = mem_q[raddr_f_i];
    assign rdata_r_o = mem_q[raddr_r_i];

endmodule

// File: rtl/ftq.sv
// Fetch target queue. Buffers predictor bundles by FTQ id, serves fetch
// blocks in order, and turns backend resolutions into one-cycle predictor
// updates (redir on mispredict, reinf on correct prediction). A mispredict
// flushes the whole queue on the edge that raises redir.
//   clk, rst          : clock, async active-high reset
//   pg_in / pg_ready  : bundle input from the predictor
//   f_*               : fetch block output
//   res_*             : branch resolution input
//   cm_valid          : commit (frees head entry)
//   redir .. ught     : registered predictor update outputs
module ftq
    import ftq_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned FNUM  = 4,
    parameter int unsigned CNT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  pcg_bundle_t              pg_in,
    output logic                     pg_ready,
    output logic                     f_valid,
    input  logic                     f_ready,
    output logic [63:0]              f_pc,
    output logic [7:0]               f_num,
    output logic [6:0]               f_id,
    input  logic                     res_valid,
    input  logic [6:0]               res_id,
    input  logic [7:0]               res_slot,
    input  logic                     res_mispred,
    input  logic [63:0]              res_target,
    input  logic                     cm_valid,
    output logic                     redir,
    output logic                     reinf,
    output logic [63:0]              upc,
    output logic [63:0]              unpc,
    output logic [4:0]               ubk,
    output logic [7:0]               upat,
    output logic [7:0]               upatb,
    output logic [15:0]              ugh,
    output logic [FTQ_NH-1:0][15:0]  ughi,
    output logic [FTQ_NH-1:0][15:0]  ught
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned SW = (FNUM > 1) ? $clog2(FNUM) : 1;

    logic [PW-1:0]    head_q, head_d, fetch_q, fetch_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    ftq_upd_t         upd_q, upd_d;

    ftq_entry_t       wr_ent, f_ent, r_ent;
    logic             full, enq, deq, cm_ok, res_ok;
    logic [IW-1:0]    res_idx;
    logic [SW-1:0]    slot;

    assign full     = (tail_q[IW-1:0] == head_q[IW-1:0]) && (tail_q[IW] != head_q[IW]);
    assign pg_ready = ~full & ~upd_q.redir;
    assign enq      = pg_in.id[7] & pg_ready;
    assign f_valid  = (fetch_q != tail_q);
    assign deq      = f_valid & f_ready;
    assign cm_ok    = cm_valid & (head_q != fetch_q);
    assign res_idx  = res_id[IW-1:0];
    assign slot     = res_slot[SW-1:0];
    // A resolution arriving during the redir cycle targets pre-flush ids.
    assign res_ok   = res_valid & ~upd_q.redir & valid_q[res_idx] & (res_slot < 8'(FNUM));

    always_comb begin
        wr_ent      = '0;
        wr_ent.pc   = pg_in.pc;
        wr_ent.num  = pg_in.num;
        wr_ent.bank = pg_in.bank;
        wr_ent.pat  = pg_in.pat;
        wr_ent.patb = pg_in.patb;
        wr_ent.gh   = pg_in.gh;
        wr_ent.ghi  = pg_in.ghi;
        wr_ent.ght  = pg_in.ght;
    end

    ftq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i     (clk),
        .we_i      (enq),
        .waddr_i   (tail_q[IW-1:0]),
        .wdata_i   (wr_ent),
        .raddr_f_i (fetch_q[IW-1:0]),
        .rdata_f_o (f_ent),
        .raddr_r_i (res_idx),
        .rdata_r_o (r_ent)
    );

    assign f_pc  = f_ent.pc;
    assign f_num = f_ent.num;
    assign f_id  = 7'(fetch_q);

    always_comb begin
        head_d    = head_q;
        fetch_d   = fetch_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        upd_d     = upd_q;
        upd_d.redir = 1'b0;
        upd_d.reinf = 1'b0;
        if (enq) begin
            valid_d[tail_q[IW-1:0]] = 1'b1;
            tail_d = tail_q + 1'b1;
        end
        if (deq) fetch_d = fetch_q + 1'b1;
        if (cm_ok) begin
            valid_d[head_q[IW-1:0]] = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (res_ok) begin
            upd_d.redir = res_mispred;
            upd_d.reinf = ~res_mispred;
            upd_d.pc    = r_ent.pc + 64'({res_slot, 1'b0});
            upd_d.npc   = res_target;
            upd_d.bk    = r_ent.bank[slot];
            upd_d.pat   = r_ent.pat[slot];
            upd_d.patb  = r_ent.patb[slot];
            upd_d.gh    = r_ent.gh[slot];
            upd_d.ghi   = r_ent.ghi[slot];
            upd_d.ght   = r_ent.ght[slot];
            // Flush overrides any same-cycle enqueue/fetch/commit effects.
            if (res_mispred) begin
                head_d  = '0;
                fetch_d = '0;
                tail_d  = '0;
                valid_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            fetch_q <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            upd_q   <= '0;
        end else begin
            head_q  <= head_d;
            fetch_q <= fetch_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end

    assign redir = upd_q.redir;
    assign reinf = upd_q.reinf;
    assign upc   = upd_q.pc;
    assign unpc  = upd_q.npc;
    assign ubk   = upd_q.bk;
    assign upat  = upd_q.pat;
    assign upatb = upd_q.patb;
    assign ugh   = upd_q.gh;
    assign ughi  = upd_q.ghi;
    assign ught  = upd_q.ght;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (FNUM == FTQ_FNUM && CNT == FTQ_CNT)
                else $error("ftq: FNUM/CNT disagree with predictor");
            assert (!enq || pg_in.id[6:0] == 7'(tail_q))
                else $error("ftq: enqueue id %0d != tail %0d", pg_in.id[6:0], tail_q);
            assert (!cm_valid || cm_ok)
                else $error("ftq: commit with nothing fetched");
            assert (!res_valid || upd_q.redir || res_ok)
                else $error("ftq: bad resolution id %0d slot %0d (entry num %0d)",
                            res_id, res_slot, r_ent.num);
        end
    end

endmodule

// File: tb/tb_ftq.sv
module tb_ftq;
    import ftq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    pcg_bundle_t       pg_in;
    logic              pg_ready, f_valid, f_ready;
    logic [63:0]       f_pc;
    logic [7:0]        f_num;
    logic [6:0]        f_id;
    logic              res_valid, res_mispred, cm_valid;
    logic [6:0]        res_id;
    logic [7:0]        res_slot;
    logic [63:0]       res_target;
    logic              redir, reinf;
    logic [63:0]       upc, unpc;
    logic [4:0]        ubk;
    logic [7:0]        upat, upatb;
    logic [15:0]       ugh;
    logic [FTQ_NH-1:0][15:0] ughi, ught;

    int errors = 0;
    int checks = 0;
    int next_id = 0;

    ftq #(.DEPTH(32), .FNUM(4), .CNT(2)) dut (
        .clk(clk), .rst(rst), .pg_in(pg_in), .pg_ready(pg_ready),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_num(f_num), .f_id(f_id),
        .res_valid(res_valid), .res_id(res_id), .res_slot(res_slot),
        .res_mispred(res_mispred), .res_target(res_target), .cm_valid(cm_valid),
        .redir(redir), .reinf(reinf), .upc(upc), .unpc(unpc), .ubk(ubk),
        .upat(upat), .upatb(upatb), .ugh(ugh), .ughi(ughi), .ught(ught)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pcg_bundle_t mk(input int id, input logic [63:0] pc,
                                       input logic [4:0] bk2, input logic [7:0] p2);
        pcg_bundle_t b;
        b           = '0;
        b.id        = {1'b1, 7'(id)};
        b.pc        = pc;
        b.num       = 8'd4;
        b.bank[2]   = bk2;
        b.bank[1]   = 5'h1F;
        b.pat[2]    = p2;
        b.patb[2]   = ~p2;
        b.gh[2]     = {8'hA5, p2};
        b.ghi[2][1] = 16'h1111 + pc[15:0];
        b.ght[2][3] = 16'h7777;
        return b;
    endfunction

    task automatic enq(input logic [63:0] pc, input logic [4:0] bk2, input logic [7:0] p2);
        pg_in = mk(next_id, pc, bk2, p2);
        tick();
        pg_in   = '0;
        next_id = (next_id + 1) % 64;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        next_id = 0;
        tick();
    endtask

    task automatic idle_inputs();
        pg_in = '0; f_ready = 1'b0; res_valid = 1'b0; res_id = '0; res_slot = '0;
        res_mispred = 1'b0; res_target = '0; cm_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %b want 0", f_valid); end
        checks++; if (redir !== 1'b0 || reinf !== 1'b0) begin errors++; $display("FAIL reset_upd got redir=%b reinf=%b want 0 0", redir, reinf); end
        checks++; if (upc !== 64'h0 || ubk !== 5'h0) begin errors++; $display("FAIL reset_fields got upc=%h ubk=%h want 0 0", upc, ubk); end
        checks++; if (pg_ready !== 1'b1) begin errors++; $display("FAIL reset_pg_ready got %b want 1", pg_ready); end
        do_reset();
    endtask

    task automatic test_fetch_order();
        logic [63:0] exp_pc;
        enq(64'h8000_0000, 5'h0, 8'h0);
        enq(64'h8000_0008, 5'h0, 8'h0);
        enq(64'h8000_0010, 5'h0, 8'h0);
        f_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 64'h8000_0000 + 64'(i * 8);
            checks++; if (f_valid !== 1'b1 || f_pc !== exp_pc || f_id !== 7'(i) || f_num !== 8'd4) begin
                errors++; $display("FAIL fetch_%0d got v=%b pc=%h id=%0d num=%0d want 1 %h %0d 4", i, f_valid, f_pc, f_id, f_num, exp_pc, i);
            end
            tick();
        end
        f_ready = 1'b0;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL fetch_empty got %b want 0", f_valid); end
        cm_valid = 1'b1;
        repeat (3) tick();
        cm_valid = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) begin
            checks++; if (pg_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, pg_ready); end
            enq(64'h9000_0000 + 64'(i * 16), 5'h0, 8'h0);
        end
        checks++; if (pg_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", pg_ready); end
        checks++; if (f_id !== 7'd3) begin errors++; $display("FAIL full_first_id got %0d want 3", f_id); end
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        // commit plus enqueue attempt while full: enqueue is refused this cycle
        cm_valid = 1'b1;
        pg_in    = mk(next_id, 64'hDEAD_0000, 5'h0, 8'h0);
        #1;
        checks++; if (pg_ready !== 1'b0) begin errors++; $display("FAIL full_commit_same_cycle got %b want 0", pg_ready); end
        tick();
        cm_valid = 1'b0;
        pg_in    = '0;
        checks++; if (pg_ready !== 1'b1) begin errors++; $display("FAIL after_commit_ready got %b want 1", pg_ready); end
        enq(64'hA000_0000, 5'h0, 8'h0);
        checks++; if (pg_ready !== 1'b0) begin errors++; $display("FAIL refull_ready got %b want 0", pg_ready); end
        f_ready = 1'b1;
        checks++; if (f_id !== 7'd4 || f_pc !== 64'h9000_0010) begin errors++; $display("FAIL drain_head got id=%0d pc=%h want 4 90000010", f_id, f_pc); end
        for (int i = 0; i < 40 && f_valid; i++) begin
            if (i == 31) begin
                checks++; if (f_pc !== 64'hA000_0000 || f_id !== 7'd35) begin errors++; $display("FAIL drain_last got id=%0d pc=%h want 35 a0000000", f_id, f_pc); end
            end
            tick();
        end
        f_ready = 1'b0;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", f_valid); end
        cm_valid = 1'b1;
        repeat (32) tick();
        cm_valid = 1'b0;
        checks++; if (pg_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", pg_ready); end
    endtask

    task automatic setup_id5();
        do_reset();
        for (int i = 0; i < 5; i++) enq(64'h100 * 64'(i), 5'h0, 8'h0);
        enq(64'h1000, 5'b00110, 8'h2);
    endtask

    task automatic test_reinf();
        setup_id5();
        res_valid = 1'b1; res_id = 7'd5; res_slot = 8'd2; res_mispred = 1'b0; res_target = 64'h2000;
        tick();
        res_valid = 1'b0;
        checks++; if (reinf !== 1'b1 || redir !== 1'b0) begin errors++; $display("FAIL reinf_flags got reinf=%b redir=%b want 1 0", reinf, redir); end
        checks++; if (upc !== 64'h1004 || unpc !== 64'h2000) begin errors++; $display("FAIL reinf_pc got upc=%h unpc=%h want 1004 2000", upc, unpc); end
        checks++; if (ubk !== 5'b00110 || upat !== 8'h2 || upatb !== 8'hFD || ugh !== 16'hA502) begin
            errors++; $display("FAIL reinf_slot got ubk=%b upat=%h upatb=%h ugh=%h want 00110 02 fd a502", ubk, upat, upatb, ugh);
        end
        checks++; if (ughi !== 64'h0000_0000_2111_0000 || ught !== 64'h7777_0000_0000_0000) begin
            errors++; $display("FAIL reinf_hist got ughi=%h ught=%h want 0000000021110000 7777000000000000", ughi, ught);
        end
        checks++; if (f_valid !== 1'b1 || pg_ready !== 1'b1) begin errors++; $display("FAIL reinf_no_flush got v=%b rdy=%b want 1 1", f_valid, pg_ready); end
        tick();
        checks++; if (reinf !== 1'b0) begin errors++; $display("FAIL reinf_pulse got %b want 0", reinf); end
    endtask

    task automatic test_redir();
        setup_id5();
        res_valid = 1'b1; res_id = 7'd5; res_slot = 8'd2; res_mispred = 1'b1; res_target = 64'h3000;
        tick();
        res_valid = 1'b0;
        checks++; if (redir !== 1'b1 || reinf !== 1'b0 || unpc !== 64'h3000) begin errors++; $display("FAIL redir_flags got redir=%b reinf=%b unpc=%h want 1 0 3000", redir, reinf, unpc); end
        checks++; if (pg_ready !== 1'b0 || f_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle got rdy=%b v=%b want 0 0", pg_ready, f_valid); end
        // offered during the redir cycle: must be dropped
        pg_in = mk(0, 64'hDEAD_0000, 5'h0, 8'h0);
        tick();
        pg_in = '0;
        checks++; if (redir !== 1'b0 || f_valid !== 1'b0 || pg_ready !== 1'b1) begin errors++; $display("FAIL redir_after got redir=%b v=%b rdy=%b want 0 0 1", redir, f_valid, pg_ready); end
        next_id = 0;
        enq(64'h4000, 5'h0, 8'h0);
        checks++; if (f_valid !== 1'b1 || f_id !== 7'd0 || f_pc !== 64'h4000) begin errors++; $display("FAIL redir_restart got v=%b id=%0d pc=%h want 1 0 4000", f_valid, f_id, f_pc); end
    endtask

    task automatic test_redir_concurrent();
        int pulses;
        do_reset();
        enq(64'h5000, 5'h0, 8'h0);
        enq(64'h5008, 5'h0, 8'h0);
        res_valid = 1'b1; res_id = 7'd0; res_slot = 8'd1; res_mispred = 1'b1; res_target = 64'h6000;
        pg_in = mk(next_id, 64'h5010, 5'h0, 8'h0);
        f_ready = 1'b1;
        tick();
        idle_inputs();
        pulses = 0;
        checks++; if (upc !== 64'h5002) begin errors++; $display("FAIL conc_upc got %h want 5002", upc); end
        for (int i = 0; i < 4; i++) begin
            if (redir === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL conc_redir_pulses got %0d want 1", pulses); end
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL conc_empty got %b want 0", f_valid); end
        next_id = 0;
        enq(64'h7000, 5'h0, 8'h0);
        checks++; if (f_id !== 7'd0 || f_pc !== 64'h7000) begin errors++; $display("FAIL conc_restart got id=%0d pc=%h want 0 7000", f_id, f_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enq(64'hB000, 5'h0, 8'h0);
        enq(64'hB008, 5'h0, 8'h0);
        res_valid = 1'b1; res_id = 7'd1; res_slot = 8'd0; res_mispred = 1'b0; res_target = 64'hC000;
        tick();
        res_valid = 1'b0;
        checks++; if (reinf !== 1'b1 || f_valid !== 1'b1) begin errors++; $display("FAIL async_pre got reinf=%b v=%b want 1 1", reinf, f_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (redir !== 1'b0 || reinf !== 1'b0 || f_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got redir=%b reinf=%b v=%b want 0 0 0", redir, reinf, f_valid);
        end
        #1;
        rst = 1'b0;
        next_id = 0;
        tick();
        enq(64'hE000, 5'h0, 8'h0);
        checks++; if (f_id !== 7'd0 || f_pc !== 64'hE000 || f_valid !== 1'b1) begin errors++; $display("FAIL async_restart got id=%0d pc=%h v=%b want 0 e000 1", f_id, f_pc, f_valid); end
    endtask

    initial begin
        test_reset();
        test_fetch_order();
        test_full();
        test_reinf();
        test_redir();
        test_redir_concurrent();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
